// File: rtl/seq_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM state encoding
// and the default 10110 pattern with its width.
// Build option: SEQ_TX_GAP_EN adds the GAP state (idle cycles between repeats).
package seq_tx_pkg;

  localparam int DEF_PAT_W = 5;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 5'b10110;

  // Fixed encodings so the debug state value is the same in both builds.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
`ifdef SEQ_TX_GAP_EN
    ST_DONE  = 2'd2,
    ST_GAP   = 2'd3
`else
    ST_DONE  = 2'd2
`endif
  } state_t;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Control/serial bundle between a run requester and seq_pattern_tx.
//
// Handshake: start is a level request that the transmitter samples only in
// IDLE; an edge with start==1 and count!=0 accepts the run and latches count.
// There is no ready signal: busy/done report progress, and start/count are
// ignored everywhere except IDLE. stop is a sticky graceful-abort request.
// valid qualifies j: j carries a pattern bit exactly in cycles with valid==1.
interface seq_pattern_tx_if #(
  parameter int CNT_W = 4
) ();

  logic             start;
  logic [CNT_W-1:0] count;
  logic             stop;
  logic             j;
  logic             valid;
  logic             busy;
  logic             done;

  // Requester side: issues runs, watches the serial stream.
  modport master (
    output start, count, stop,
    input  j, valid, busy, done
  );

  // Transmitter side.
  modport slave (
    input  start, count, stop,
    output j, valid, busy, done
  );

endinterface

// File: rtl/seq_pattern_tx_piso_shift.sv
// Parallel-in serial-out register: parallel load, shift-left, MSB out.
// Vacated bits fill with the idle level, so once the last pattern bit has
// been shifted out the MSB already sits at the idle level.
module piso_shift #(
  parameter int   W    = 5,
  parameter logic FILL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] q;

  // Load has priority over shift; clear/reset park the register at the fill level.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      q <= {W{FILL}};
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[W-2:0], FILL};
    end
  end

  assign msb = q[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends PATTERN MSB-first on j, one bit per
// clock, repeated count times, then pulses done for one cycle.
// Build option: SEQ_TX_GAP_EN inserts GAP_LEN idle cycles between repeats.
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int               PAT_W    = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN  = DEF_PATTERN,
  parameter int               CNT_W    = 4,
`ifdef SEQ_TX_GAP_EN
  parameter int               GAP_LEN  = 2,
`endif
  parameter logic             IDLE_LVL = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  seq_pattern_tx_if.slave     bus,
  output state_t              dbg_state
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

`ifdef SEQ_TX_GAP_EN
  localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_LEN - 1);
  logic [GAP_W-1:0] gap_q, gap_d;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] reps_q, reps_d, reps_after;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             stop_q, stop_d, stop_seen;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load, shift, clear;
  logic             j_bit;

  piso_shift #(
    .W    (PAT_W),
    .FILL (IDLE_LVL)
  ) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .clear (clear),
    .din   (PATTERN),
    .msb   (j_bit)
  );

  // Next-state and next-output logic; every register update is decided here.
  always_comb begin
    state_d    = state_q;
    reps_d     = reps_q;
    idx_d      = idx_q;
    stop_d     = stop_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    clear      = 1'b0;
    stop_seen  = stop_q | bus.stop;
    // Saturating decrement: the repeat counter never wraps below zero.
    reps_after = (reps_q != '0) ? reps_q - CNT_W'(1) : reps_q;
`ifdef SEQ_TX_GAP_EN
    gap_d      = gap_q;
`endif

    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        stop_d  = 1'b0;
        if (bus.start && (bus.count != '0)) begin
          state_d = ST_SHIFT;
          reps_d  = bus.count;
          idx_d   = '0;
          load    = 1'b1;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      ST_SHIFT: begin
        stop_d = stop_seen;
        if (idx_q != LAST_IDX) begin
          shift = 1'b1;
          idx_d = idx_q + IDX_W'(1);
        end else begin
          reps_d = reps_after;
          idx_d  = '0;
          if ((reps_after != '0) && !stop_seen) begin
`ifdef SEQ_TX_GAP_EN
            state_d = ST_GAP;
            clear   = 1'b1;
            valid_d = 1'b0;
            gap_d   = '0;
`else
            load    = 1'b1;
`endif
          end else begin
            state_d = ST_DONE;
            clear   = 1'b1;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            stop_d  = 1'b0;
          end
        end
      end

`ifdef SEQ_TX_GAP_EN
      ST_GAP: begin
        stop_d = stop_seen;
        if (gap_q == LAST_GAP) begin
          if (stop_seen) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            stop_d  = 1'b0;
          end else begin
            state_d = ST_SHIFT;
            load    = 1'b1;
            idx_d   = '0;
            valid_d = 1'b1;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
`endif

      ST_DONE: begin
        state_d = ST_IDLE;
        stop_d  = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        stop_d  = 1'b0;
      end
    endcase
  end

  // State, counters and registered status outputs; reset aborts any run silently.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      reps_q  <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_TX_GAP_EN
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      reps_q  <= reps_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SEQ_TX_GAP_EN
      gap_q   <= gap_d;
`endif
    end
  end

  assign bus.j     = j_bit;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign dbg_state = state_q;

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial pattern transmitter: the driving end for the Moore 10110 detector.
- Emits a fixed PAT_W-bit pattern (default 10110) MSB-first on a one-bit serial line, one bit per clock.
- Repeats the pattern a programmed number of times, then pulses done.
- Sits upstream of the detector's serial input j; replaces hand-timed stimulus with a clocked source.

Parameters:
- PAT_W, 5, pattern length in bits (>=2).
- PATTERN, 5'b10110, pattern bits; MSB is sent first.
- CNT_W, 4, width of the repeat-count input.
- IDLE_LVL, 1'b0, level driven on j when no pattern bit is being sent.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- start  input  1  request; sampled only in IDLE.
- count  input  CNT_W  number of pattern repetitions; latched when start is accepted.
- stop  input  1  graceful abort; finish the current pattern, then end.
- j  output  1  serial data out, registered.
- valid  output  1  high while j carries a pattern bit.
- busy  output  1  high from the cycle after start is accepted through the last bit.
- done  output  1  one-cycle pulse after the final bit.

Behaviour:
- Reset (rst==0 at an edge): state=IDLE, j=IDLE_LVL, valid=0, busy=0, done=0, repeat counter=0, bit index=0, stop flag=0. Reset overrides every other input and aborts any run mid-pattern with no done pulse.
- States: IDLE, SHIFT, GAP (only with the feature enabled), DONE.
- IDLE:
  - start==1 and count!=0: latch reps=count, load the shift register with PATTERN, set bit_idx=0, go to SHIFT.
  - The same edge registers j=PATTERN[PAT_W-1], valid=1, busy=1. Latency from the accepting edge to the first bit is 0 cycles.
  - start==1 with count==0: ignored; stays IDLE, no done.
  - stop is ignored in IDLE.
- SHIFT:
  - Each edge presents the next bit, MSB to LSB. Each bit is held exactly one clock.
  - On the edge after bit_idx==PAT_W-1, reps is decremented.
  - If reps_after>0 and the stop flag is clear: reload PATTERN and continue in SHIFT (or go to GAP). Back-to-back patterns have no idle cycle between them.
  - Otherwise go to DONE: j=IDLE_LVL, valid=0, busy=0, done=1.
- stop:
  - stop==1 at any edge in SHIFT (or GAP) sets a sticky flag.
  - The current pattern always completes; partial patterns are never emitted. The flag clears in DONE.
- DONE: lasts one cycle with done=1, then returns to IDLE. start is not accepted during DONE.
- start and count are ignored while busy; a new run needs IDLE.
- Timing for a run of R patterns, with no stop and no gaps:
  - valid is high for exactly R*PAT_W consecutive cycles.
  - done is high in the cycle immediately after the last valid bit.
- The repeat counter is CNT_W bits and never wraps: a decrement happens only while reps>=1.

Optional Feature:
- Macro SEQ_TX_GAP_EN.
- Defined:
  - Adds parameter GAP_LEN (default 2) and state GAP.
  - Between consecutive repetitions, j is held at IDLE_LVL with valid=0 and busy=1 for GAP_LEN cycles. There is no gap after the final pattern.
  - stop during GAP ends the run: go to DONE at the end of the gap.
- Undefined: GAP state and parameter are absent; repetitions are contiguous.

Decomposition:
- Package seq_tx_pkg holds:
  - the state encoding constants (IDLE, SHIFT, GAP, DONE);
  - the default pattern constant 5'b10110 and its width.
- One natural sub-module: piso_shift (parallel load, shift-left, MSB output, width PAT_W), instantiated once.
- The FSM and counters stay in seq_pattern_tx.

Test Plan:
- Reset: hold rst=0 for 2 cycles while start=1 -> j=0, valid=0, busy=0, done=0 throughout.
- Single pattern: count=1, start for 1 cycle.
  - j = 1,0,1,1,0 on 5 consecutive cycles with valid=1.
  - done=1 on cycle 6; busy low again on cycle 6.
- Repeat and detector link: count=3.
  - j = 101101011010110 with valid high for 15 cycles, done on cycle 16.
  - A detector_verilog instance on j asserts w exactly 3 times.
- Stop mid-run: count=4, stop pulsed during bit 3 of pattern 2 -> pattern 2 completes, 10 valid bits total, done on cycle 11.
- Count zero and busy start: start with count=0 -> no activity; start re-asserted while busy -> ignored, bit stream unchanged.
- Reset mid-pattern: rst=0 at bit 2 -> next cycle j=0, valid=0, busy=0, no done pulse.
- Gap build (SEQ_TX_GAP_EN, GAP_LEN=2), count=2 -> 10110, two idle cycles with valid=0, 10110, then done.
